// File: rtl/fproc_meas_responder_if.sv
// Bundles the fproc request/response lines and the readout write port of
// fproc_meas_responder. The master modport is the side that issues requests and
// writes results; the slave modport is the responder.
// With FPROC_TIMEOUT_EN defined the bundle also carries the per-core timeout_err flags.
interface fproc_meas_responder_if #(
  parameter int unsigned N_CORES        = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FPROC_ID_WIDTH = 8,
  parameter int unsigned N_MEAS         = 16
);
  localparam int unsigned IdxW = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;

  logic [N_CORES-1:0]                fproc_enable;
  logic [N_CORES*FPROC_ID_WIDTH-1:0] fproc_id;
  logic [N_CORES-1:0]                fproc_ready;
  logic [N_CORES*DATA_WIDTH-1:0]     fproc_data;
  logic                              meas_valid;
  logic [IdxW-1:0]                   meas_idx;
  logic [DATA_WIDTH-1:0]             meas_data;
  logic                              meas_clear;
`ifdef FPROC_TIMEOUT_EN
  logic [N_CORES-1:0]                timeout_err;
`endif

  modport master (
    output fproc_enable, fproc_id, meas_valid, meas_idx, meas_data, meas_clear,
`ifdef FPROC_TIMEOUT_EN
    input  timeout_err,
`endif
    input  fproc_ready, fproc_data
  );

  modport slave (
    input  fproc_enable, fproc_id, meas_valid, meas_idx, meas_data, meas_clear,
`ifdef FPROC_TIMEOUT_EN
    output timeout_err,
`endif
    output fproc_ready, fproc_data
  );

endinterface

// File: rtl/fproc_meas_responder.sv
// Responder end of the fproc interface.
// The block keeps a store of N_MEAS result slots, each with a valid bit.
// Each core has an independent IDLE/WAIT FSM. A request that hits a valid slot, or a slot
// written in the same cycle, is answered on the next cycle. A request that misses waits
// for a matching write and is then answered with the written data on the next cycle.
// Optional feature macro FPROC_TIMEOUT_EN: a waiting request gives up after TIMEOUT_CYCLES.
// On timeout it answers all ones and sets a sticky timeout_err bit for that core.
// The interface parameters must match this module's parameters.
module fproc_meas_responder #(
  parameter int unsigned N_CORES        = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FPROC_ID_WIDTH = 8,
  parameter int unsigned N_MEAS         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  reset,
  fproc_meas_responder_if.slave bus
);

  localparam int unsigned IdxW = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;

  typedef enum logic {StIdle, StWait} state_e;

  // Result store
  logic [DATA_WIDTH-1:0] slot_q [N_MEAS];
  logic [N_MEAS-1:0]     slot_valid_q;

  // Per-core request state
  state_e                              state_q    [N_CORES];
  state_e                              state_d    [N_CORES];
  logic [IdxW-1:0]                     wait_idx_q [N_CORES];
  logic [IdxW-1:0]                     wait_idx_d [N_CORES];
  logic [N_CORES-1:0]                  ready_q, ready_d;
  logic [N_CORES-1:0][DATA_WIDTH-1:0]  data_q, data_d;

  // Decoded request fields
  logic [N_CORES-1:0][FPROC_ID_WIDTH-1:0] core_id;
  logic [IdxW-1:0]                        core_idx [N_CORES];
  logic [N_CORES-1:0]                     id_oob;
  logic [N_CORES-1:0]                     wr_hit;
  logic [N_CORES-1:0]                     wait_hit;

`ifdef FPROC_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0]    cnt_q [N_CORES];
  logic [CntW-1:0]    cnt_d [N_CORES];
  logic [N_CORES-1:0] err_q, err_set;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign core_id         = bus.fproc_id;
  assign bus.fproc_ready = ready_q;
  assign bus.fproc_data  = data_q;
`ifdef FPROC_TIMEOUT_EN
  assign bus.timeout_err = err_q;
`endif

  // Decode each core's id and compare it against the write port
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      core_idx[i] = core_id[i][IdxW-1:0];
      id_oob[i]   = 32'(core_id[i]) >= N_MEAS;
      wr_hit[i]   = bus.meas_valid && (bus.meas_idx == core_idx[i]);
      wait_hit[i] = bus.meas_valid && (bus.meas_idx == wait_idx_q[i]);
    end
  end

  // Result store: the written slot stays valid even under a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_valid_q <= '0;
      for (int s = 0; s < N_MEAS; s++) begin
        slot_q[s] <= '0;
      end
    end else begin
      if (bus.meas_clear) begin
        slot_valid_q <= '0;
      end
      if (bus.meas_valid) begin
        slot_q[bus.meas_idx]       <= bus.meas_data;
        slot_valid_q[bus.meas_idx] <= 1'b1;
      end
    end
  end

  // Per-core FSM state and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= '0;
      data_q  <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        state_q[i]    <= StIdle;
        wait_idx_q[i] <= '0;
      end
    end else begin
      ready_q <= ready_d;
      data_q  <= data_d;
      for (int i = 0; i < N_CORES; i++) begin
        state_q[i]    <= state_d[i];
        wait_idx_q[i] <= wait_idx_d[i];
      end
    end
  end

`ifdef FPROC_TIMEOUT_EN
  // Wait counters and sticky timeout flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      err_q <= err_q | err_set;
      for (int i = 0; i < N_CORES; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`endif

  // Per-core next-state and response selection
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      state_d[i]    = state_q[i];
      wait_idx_d[i] = wait_idx_q[i];
      ready_d[i]    = 1'b0;
      data_d[i]     = data_q[i];
`ifdef FPROC_TIMEOUT_EN
      cnt_d[i]      = cnt_q[i];
      err_set[i]    = 1'b0;
`endif
      unique case (state_q[i])
        StIdle: begin
          if (bus.fproc_enable[i]) begin
            if (id_oob[i]) begin
              ready_d[i] = 1'b1;
              data_d[i]  = '0;
            end else if (wr_hit[i]) begin
              // Same-cycle write wins over the stored value
              ready_d[i] = 1'b1;
              data_d[i]  = bus.meas_data;
            end else if (slot_valid_q[core_idx[i]]) begin
              ready_d[i] = 1'b1;
              data_d[i]  = slot_q[core_idx[i]];
            end else begin
              state_d[i]    = StWait;
              wait_idx_d[i] = core_idx[i];
`ifdef FPROC_TIMEOUT_EN
              cnt_d[i]      = '0;
`endif
            end
          end
        end
        StWait: begin
          // Enables and clears are ignored here; only a matching write resolves the wait
          if (wait_hit[i]) begin
            ready_d[i] = 1'b1;
            data_d[i]  = bus.meas_data;
            state_d[i] = StIdle;
`ifdef FPROC_TIMEOUT_EN
          end else if (cnt_q[i] == CntLast) begin
            ready_d[i] = 1'b1;
            data_d[i]  = '1;
            err_set[i] = 1'b1;
            state_d[i] = StIdle;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
`endif
          end
        end
        default: begin
          state_d[i] = StIdle;
        end
      endcase
    end
  end

endmodule
